im_fetch_arbiter: RTL and testbench

- Owns the single combinational read port of im_32k (16-bit byte address in, 32-bit data out).
- Shares that port between two requesters: the sequential instruction-fetch stream, which fills a DEPTH-entry prefetch FIFO feeding decode, and a debug/loader read port using a req/ack handshake.
- Handles PC redirects (branch/jump) by flushing the FIFO.
- Sits between the PC/decode stage and im_32k.

---
 rtl/im_fetch_arbiter_pkg.sv | 15 +
 rtl/im_fetch_arbiter_fetch_fifo.sv | 66 ++++++
 rtl/im_fetch_arbiter.sv | 106 ++++++++++
 tb/tb_im_fetch_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/im_fetch_arbiter_pkg.sv
// Shared constants for the instruction-memory fetch arbiter: code segment start,
// IM address width and the read-port grant encoding.
package im_fetch_arbiter_pkg;

    localparam int IM_AW = 16;

    localparam logic [IM_AW-1:0] CODE_SEG_PC = 16'h3000;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DBG   = 2'd2
    } grant_t;

endpackage

// File: rtl/im_fetch_arbiter_fetch_fifo.sv
// Prefetch FIFO between the fetch port and decode: circular buffer with
// flush, and a head output forced to zero while empty.
module im_fetch_arbiter_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Flush wins over both push and pop in the same cycle.
    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop  && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/im_fetch_arbiter.sv
// Shares the single combinational im_32k read port between sequential
// instruction prefetch and a req/ack debug read port; redirects flush the FIFO.
module im_fetch_arbiter
    import im_fetch_arbiter_pkg::*;
#(
    parameter int             AW       = IM_AW,
    parameter int             DEPTH    = 2,
    parameter logic [AW-1:0]  RESET_PC = CODE_SEG_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] im_addr,
    input  logic [31:0]   im_dout,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [AW-1:0] inst_pc,
    input  logic          inst_ready,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata
);

    localparam int EW = 32 + AW;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] r_fetch_pc;
    logic          r_dbg_ack;
    logic [31:0]   r_dbg_rdata;
    grant_t        r_last_grant;

    grant_t        w_grant;
    logic [CW-1:0] w_count;
    logic          w_pop;
    logic          w_space;
    logic          w_push;
    logic [EW-1:0] w_head;
    logic          w_unused_bits;

    assign w_pop   = inst_valid && inst_ready;
    assign w_space = (w_count < CW'(DEPTH)) || w_pop;

    // Debug wins when fetch had the last turn or fetch cannot use the port,
    // which bounds debug latency to two cycles and alternates under contention.
    always_comb begin
        w_grant = GNT_NONE;
        if (!rst_n) begin
            w_grant = GNT_NONE;
        end else if (dbg_req && !r_dbg_ack && (r_last_grant == GNT_FETCH || !w_space)) begin
            w_grant = GNT_DBG;
        end else if (w_space && !redirect_valid) begin
            w_grant = GNT_FETCH;
        end
    end

    assign w_push  = (w_grant == GNT_FETCH);
    assign im_addr = (w_grant == GNT_DBG) ? {dbg_addr[AW-1:2], 2'b00} : r_fetch_pc;

    im_fetch_arbiter_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata ({im_dout, r_fetch_pc}),
        .o_rdata (w_head),
        .o_valid (inst_valid),
        .o_count (w_count)
    );

    assign inst    = w_head[EW-1:AW];
    assign inst_pc = w_head[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc   <= RESET_PC;
            r_dbg_ack    <= 1'b0;
            r_dbg_rdata  <= '0;
            r_last_grant <= GNT_FETCH;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[AW-1:2], 2'b00};
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + AW'(4);
            end
            r_dbg_ack <= (w_grant == GNT_DBG);
            if (w_grant == GNT_DBG) begin
                r_dbg_rdata <= im_dout;
            end
            if (w_grant != GNT_NONE) begin
                r_last_grant <= w_grant;
            end
        end
    end

    assign dbg_ack   = r_dbg_ack;
    assign dbg_rdata = r_dbg_rdata;

    assign w_unused_bits = ^{redirect_pc[1:0], dbg_addr[1:0]};

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Directed bench for im_fetch_arbiter with a combinational IM model whose
// byte at address a is a[7:0].
module tb_im_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] im_addr;
    logic [31:0] im_dout;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic        dbg_req;
    logic [15:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        logic [7:0] b;
        b = a[7:0] & 8'hFC;
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    assign im_dout = mem_word(im_addr);

    im_fetch_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_addr        (im_addr),
        .im_dout        (im_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_ack        (dbg_ack),
        .dbg_rdata      (dbg_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_head(input string tag, input logic [15:0] pc);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, {16'd0, inst_pc}, {16'd0, pc});
        chk({tag, "_inst"}, inst, mem_word(pc));
    endtask

    initial begin
        logic [15:0] pcs [3];

        rst_n          = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        dbg_req        = 1'b0;
        dbg_addr       = 16'h0000;
        repeat (2) @(negedge clk);

        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", {16'd0, inst_pc}, 32'h0);
        chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_im_addr", {16'd0, im_addr}, 32'h3000);

        rst_n = 1'b1;
        #1 chk("first_im_addr", {16'd0, im_addr}, 32'h3000);
        pcs = '{16'h3000, 16'h3004, 16'h3008};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_head("stream", pcs[k]);
        end

        inst_ready = 1'b0;
        repeat (5) tick();
        chk_head("bp_hold", 16'h3008);
        chk("bp_fetch_pc", {16'd0, im_addr}, 32'h3010);

        inst_ready = 1'b1;
        pcs = '{16'h300C, 16'h3010, 16'h3014};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_head("bp_resume", pcs[k]);
        end

        inst_ready = 1'b0;
        tick();
        chk("full_im_addr", {16'd0, im_addr}, 32'h301C);
        chk("full_head_pc", {16'd0, inst_pc}, 32'h3014);

        redirect_valid = 1'b1;
        redirect_pc    = 16'h3021;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("redir_flush_valid", {31'd0, inst_valid}, 32'd0);
        #1 chk("redir_im_addr", {16'd0, im_addr}, 32'h3020);
        pcs = '{16'h3020, 16'h3024, 16'h3028};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_head("redir", pcs[k]);
        end

        dbg_req  = 1'b1;
        dbg_addr = 16'h3010;
        #1 chk("dbg1_im_addr", {16'd0, im_addr}, 32'h3010);
        tick();
        chk("dbg1_ack", {31'd0, dbg_ack}, 32'd1);
        chk("dbg1_rdata", dbg_rdata, 32'h10111213);
        chk("dbg1_fifo_drained", {31'd0, inst_valid}, 32'd0);
        dbg_addr = 16'h3017;
        tick();
        chk("dbg_ack_no_repeat", {31'd0, dbg_ack}, 32'd0);
        chk_head("alt_fetch", 16'h302C);
        chk("dbg1_rdata_hold", dbg_rdata, 32'h10111213);
        #1 chk("dbg2_im_addr", {16'd0, im_addr}, 32'h3014);
        tick();
        chk("dbg2_ack", {31'd0, dbg_ack}, 32'd1);
        chk("dbg2_rdata", dbg_rdata, 32'h14151617);
        chk("dbg2_fifo_drained", {31'd0, inst_valid}, 32'd0);
        dbg_req = 1'b0;
        tick();
        chk("dbg_ack_drop", {31'd0, dbg_ack}, 32'd0);
        chk_head("post_dbg", 16'h3030);
        tick();
        chk_head("post_dbg", 16'h3034);

        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFF8;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_flush_valid", {31'd0, inst_valid}, 32'd0);
        pcs = '{16'hFFF8, 16'hFFFC, 16'h0000};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_head("wrap", pcs[k]);
        end

        dbg_req  = 1'b1;
        dbg_addr = 16'h3010;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_im_addr", {16'd0, im_addr}, 32'h3000);
        tick();
        chk("mid_rst_ack_held", {31'd0, dbg_ack}, 32'd0);
        chk("mid_rst_rdata", dbg_rdata, 32'h0);
        chk("mid_rst_valid_held", {31'd0, inst_valid}, 32'd0);
        dbg_req = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk_head("restart", 16'h3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
